// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch buffer entry layout, reset PC default
// and a PC alignment helper.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One prefetched instruction together with the address it came from.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // Fetch addresses are always word aligned.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding prefetched {pc, inst} entries. First-word
// fall-through: the head entry is read straight out of the storage registers,
// so nothing combinational from the push side reaches head_data.
import cpu_pkg::*;

module fetch_fifo #(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  fetch_entry_t  push_data,
   input  logic          pop,
   input  logic          flush,
   output fetch_entry_t  head_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   fetch_entry_t  mem_reg [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   // A push into a full buffer is only legal when the head leaves in the same cycle.
   assign do_push = push && !flush && (!full || pop);
   assign do_pop  = pop && !flush && !empty;
   // Empty buffer shows zeros so stale storage never appears on the outputs.
   assign head_data = empty ? '0 : mem_reg[rd_ptr_reg];

   // Storage write; contents need no reset because they are only read when valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   // Pointer and occupancy tracking; flush and reset both empty the buffer.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, tracks outstanding
// requests, drops responses made stale by a redirect and buffers the rest
// for decode.
import cpu_pkg::*;

module fetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   localparam int          CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc_reg,    fetch_pc_next;
   logic [31:0]   rsp_pc_reg,      rsp_pc_next;     // address the next kept response belongs to
   logic [CW-1:0] out_cnt_reg,     out_cnt_next;
   logic [CW-1:0] discard_cnt_reg, discard_cnt_next;
   logic          started_reg;                      // holds requests off for one cycle after reset

   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   fetch_entry_t  fifo_head;
   fetch_entry_t  push_entry;
   logic [CW:0]   inflight;
   logic          req_fire;
   logic          rsp_ok;
   logic          rsp_keep;
   logic          rsp_drop;
   logic          pop;

   // Buffered plus in-flight words may never exceed the buffer size, so every
   // response is guaranteed a slot.
   assign inflight       = {1'b0, fifo_count} + {1'b0, out_cnt_reg};
   assign imem_req_valid = started_reg && !reset && !redirect_valid && (inflight < DEPTH_W);
   assign imem_req_addr  = fetch_pc_reg;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is ignored outright.
   assign rsp_ok     = imem_rsp_valid && (out_cnt_reg != '0);
   assign rsp_drop   = rsp_ok && (discard_cnt_reg != '0);
   assign rsp_keep   = rsp_ok && (discard_cnt_reg == '0) && !redirect_valid;
   assign push_entry = '{pc: rsp_pc_reg, inst: imem_rsp_data};

   assign inst_valid = !fifo_empty;
   assign inst_data  = fifo_head.inst;
   assign inst_pc    = fifo_head.pc;
   assign pop        = inst_valid && inst_ready && !redirect_valid;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rsp_keep),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Next-state for PCs and counters; a redirect turns everything still in
   // flight into responses to be discarded.
   always_comb begin
      fetch_pc_next    = fetch_pc_reg;
      rsp_pc_next      = rsp_pc_reg;
      out_cnt_next     = out_cnt_reg;
      discard_cnt_next = discard_cnt_reg;
      if (redirect_valid) begin
         fetch_pc_next    = align_pc(redirect_pc);
         rsp_pc_next      = align_pc(redirect_pc);
         out_cnt_next     = out_cnt_reg - CW'(rsp_ok);
         discard_cnt_next = out_cnt_reg - CW'(rsp_ok);
      end else begin
         if (req_fire) fetch_pc_next = fetch_pc_reg + 32'd4;
         if (rsp_keep) rsp_pc_next   = rsp_pc_reg + 32'd4;
         if (rsp_drop) discard_cnt_next = discard_cnt_reg - CW'(1);
         out_cnt_next = out_cnt_reg + CW'(req_fire) - CW'(rsp_ok);
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_reg    <= RESET_PC;
         rsp_pc_reg      <= RESET_PC;
         out_cnt_reg     <= '0;
         discard_cnt_reg <= '0;
         started_reg     <= 1'b0;
      end else begin
         fetch_pc_reg    <= fetch_pc_next;
         rsp_pc_reg      <= rsp_pc_next;
         out_cnt_reg     <= out_cnt_next;
         discard_cnt_reg <= discard_cnt_next;
         started_reg     <= 1'b1;
      end
   end

   // Simulation-only protocol checks: no unsolicited responses, no buffer overflow.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(imem_rsp_valid && out_cnt_reg == '0));
         assert (!(rsp_keep && fifo_full && !pop));
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a request-level memory/buffer model predicts every
// output each cycle; directed scenarios add literal expectations.
module tb_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_ready = 1'b0;
   logic        imem_req_valid, inst_valid;
   logic [31:0] imem_req_addr, inst_data, inst_pc;
   logic        b_req_valid, b_inst_valid;
   logic [31:0] b_req_addr, b_inst_data, b_inst_pc;

   always #5 clk = ~clk;

   fetch_unit #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_pc(inst_pc)
   );

   // Same stimulus, different reset PC: used for the address wrap check.
   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .reset(reset),
      .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(b_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .inst_valid(b_inst_valid), .inst_ready(inst_ready),
      .inst_data(b_inst_data), .inst_pc(b_inst_pc)
   );

   typedef struct {logic [31:0] pc; int due; bit stale;} mreq_t;
   typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;

   mreq_t       pend[$];      // requests accepted by memory, not yet answered
   ent_t        mbuf[$];      // instructions the unit must currently hold
   logic [31:0] q_fire[$];    // accepted request addresses since reset
   logic [31:0] m_pc;
   int          cyc, n_tests, n_fail, n_drop, n_pop;
   int          lat_lo, lat_hi;
   bit          s_rdy, s_ird, s_redir;
   logic [31:0] s_rpc;
   bit          got_first;
   logic [31:0] first_pc;
   bit          v_at[64], rq_at[64], b_rq_at[64];
   logic [31:0] pc_at[64], data_at[64], ra_at[64], b_ra_at[64];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, advance.
   task automatic step();
      mreq_t h;
      bit    rsp, keep, exp_rv, exp_iv, fire, pop;
      keep = 1'b0;
      imem_req_ready = s_rdy;
      inst_ready     = s_ird;
      redirect_valid = s_redir;
      redirect_pc    = s_rpc;
      rsp = (pend.size() > 0) && (pend[0].due <= cyc);
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? mem_word(pend[0].pc) : $urandom;
      #1;
      exp_rv = (cyc >= 1) && !s_redir && (mbuf.size() + pend.size() < DEPTH);
      exp_iv = (mbuf.size() != 0);
      check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      check("req_addr", imem_req_addr, m_pc);
      check("inst_valid", 32'(inst_valid), 32'(exp_iv));
      if (exp_iv) begin
         check("inst_pc", inst_pc, mbuf[0].pc);
         check("inst_data", inst_data, mbuf[0].data);
      end
      if (cyc == 0) begin
         check("rst_inst_pc", inst_pc, 32'h0);
         check("rst_inst_data", inst_data, 32'h0);
      end
      if (cyc < 64) begin
         v_at[cyc] = inst_valid;     pc_at[cyc] = inst_pc;   data_at[cyc] = inst_data;
         rq_at[cyc] = imem_req_valid; ra_at[cyc] = imem_req_addr;
         b_rq_at[cyc] = b_req_valid;  b_ra_at[cyc] = b_req_addr;
      end
      fire = exp_rv && s_rdy;
      pop  = exp_iv && s_ird && !s_redir;
      if (rsp) begin
         h = pend.pop_front();
         keep = !h.stale && !s_redir;
         if (!keep) n_drop++;
      end
      if (pop) begin
         $display("[TB] cyc=%0d deliver pc=%h data=%h", cyc, mbuf[0].pc, mbuf[0].data);
         if (!got_first) begin
            got_first = 1'b1;
            first_pc = mbuf[0].pc;
         end
         n_pop++;
         void'(mbuf.pop_front());
      end
      if (s_redir) begin
         $display("[TB] cyc=%0d redirect pc=%h", cyc, s_rpc);
         mbuf.delete();
         foreach (pend[i]) pend[i].stale = 1'b1;
         m_pc = {s_rpc[31:2], 2'b00};
         got_first = 1'b0;
      end else begin
         if (keep) mbuf.push_back('{h.pc, mem_word(h.pc)});
         if (fire) begin
            pend.push_back('{m_pc, cyc + int'($urandom_range(lat_hi, lat_lo)), 1'b0});
            q_fire.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      s_redir = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      pend.delete();
      mbuf.delete();
      q_fire.delete();
      m_pc = 32'h0;
      cyc = 0; n_drop = 0; n_pop = 0;
      got_first = 1'b0; first_pc = '0;
      for (int i = 0; i < 64; i++) begin
         v_at[i] = 0; rq_at[i] = 0; b_rq_at[i] = 0;
         pc_at[i] = '0; data_at[i] = '0; ra_at[i] = '0; b_ra_at[i] = '0;
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      s_rpc = '0;

      // Streaming with a one-cycle memory.
      lat_lo = 1; lat_hi = 1; s_rdy = 1; s_ird = 1;
      do_reset();
      repeat (8) step();
      check("t1_no_req_cyc0", 32'(rq_at[0]), 32'h0);
      check("t1_req_addr_1", ra_at[1], 32'h0);
      check("t1_req_addr_2", ra_at[2], 32'h4);
      check("t1_valid_cyc2", 32'(v_at[2]), 32'h0);
      check("t1_valid_cyc3", 32'(v_at[3]), 32'h1);
      check("t1_pc_cyc3", pc_at[3], 32'h0);
      check("t1_pc_cyc4", pc_at[4], 32'h4);
      check("t1_pc_cyc5", pc_at[5], 32'h8);
      check("t1_data_cyc3", data_at[3], 32'h1357_6420);
      check("wrap_req_1", {b_rq_at[1], b_ra_at[1]}, {1'b1, 32'hFFFF_FFF8});
      check("wrap_req_2", {b_rq_at[2], b_ra_at[2]}, {1'b1, 32'hFFFF_FFFC});
      check("wrap_req_3", {b_rq_at[3], b_ra_at[3]}, {1'b1, 32'h0000_0000});

      // Decode stalled: buffer fills, fetching stops, then resumes at 0x10.
      s_ird = 0;
      do_reset();
      repeat (10) step();
      check("t2_req_count", q_fire.size(), 32'd4);
      check("t2_req_low", 32'(rq_at[9]), 32'h0);
      check("t2_buf_valid", 32'(v_at[9]), 32'h1);
      s_ird = 1;
      repeat (4) step();
      check("t2_resume_addr", (q_fire.size() > 4) ? q_fire[4] : 32'hDEAD_BEEF, 32'h10);

      // Three-cycle memory, two requests in flight when redirected to 0x100.
      lat_lo = 3; lat_hi = 3;
      do_reset();
      repeat (3) step();
      s_redir = 1; s_rpc = 32'h100;
      step();
      s_redir = 0;
      repeat (12) step();
      check("t3_dropped", n_drop, 32'd2);
      check("t3_first_pc", first_pc, 32'h100);

      // Unaligned redirect target.
      lat_lo = 1; lat_hi = 1;
      repeat (4) step();
      s_redir = 1; s_rpc = 32'h203;
      step();
      s_redir = 0;
      step();
      check("t4_req_valid", 32'(rq_at[cyc-1]), 32'h1);
      check("t4_req_addr", ra_at[cyc-1], 32'h200);

      // Back-to-back redirects: the later one wins.
      lat_lo = 2; lat_hi = 4;
      repeat (6) step();
      s_redir = 1; s_rpc = 32'h400;
      step();
      s_rpc = 32'h800;
      step();
      s_redir = 0;
      repeat (15) step();
      check("t5_first_pc", first_pc, 32'h800);

      // Random stalls, latencies and redirects, with one reset mid-stream.
      lat_lo = 1; lat_hi = 5;
      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         s_rdy   = ($urandom_range(0, 3) != 0);
         s_ird   = ($urandom_range(0, 3) != 0);
         s_redir = ($urandom_range(0, 39) == 0);
         s_rpc   = $urandom;
         step();
      end
      check("t6_progress", 32'(n_pop > 20), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, sets prefetch buffer entries and the maximum outstanding requests; power of two, >=2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset.
REQ-003 Reset is reset, synchronous, active-high; clock is clk.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 imem_req_valid  output  1  fetch request present.
REQ-007 imem_req_ready  input  1  instruction memory accepts request.
REQ-008 imem_req_addr  output  32  word-aligned fetch address.
REQ-009 imem_rsp_valid  input  1  response word present; responses return in request order, latency >=1 cycle.
REQ-010 imem_rsp_data  input  32  instruction word.
REQ-011 redirect_valid  input  1  control-flow change; flushes the unit.
REQ-012 redirect_pc  input  32  new fetch address.
REQ-013 inst_valid  output  1  instruction available to decode.
REQ-014 inst_ready  input  1  decode consumes instruction.
REQ-015 inst_data  output  32  instruction at buffer head.
REQ-016 inst_pc  output  32  address of inst_data.

Function
REQ-017 Request handshake completes when imem_req_valid and imem_req_ready are both high; fetch_pc then advances by 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-018 imem_req_addr equals fetch_pc whenever imem_req_valid is high; imem_req_valid and imem_req_addr remain stable until accepted unless a redirect occurs.
REQ-019 imem_req_valid is high only when buffer occupancy plus outstanding requests < DEPTH and redirect_valid is low.
REQ-020 Outstanding counter, width clog2(DEPTH+1): +1 on request handshake, -1 on each imem_rsp_valid, both in the same cycle leave it unchanged.
REQ-021 Each non-discarded response pushes {pc, data} into the buffer; the pc is the address of the matching request.
REQ-022 inst_valid equals buffer not-empty; inst_data/inst_pc are the head entry, driven from registered storage with no combinational path from imem_rsp_*.
REQ-023 Pop occurs when inst_valid and inst_ready are high; push and pop in one cycle keep occupancy unchanged, including at full.
REQ-024 Minimum latency: response arriving in cycle N produces inst_valid in cycle N+1.
REQ-025 Redirect in cycle N: buffer emptied and fetch_pc <= {redirect_pc[31:2], 2'b00} at edge N; inst_valid is low in N+1; first new request is presented in N+1.
REQ-026 Redirect loads a discard counter with outstanding requests not yet answered (excluding any response in cycle N); those responses are dropped, not pushed.
REQ-027 Response coinciding with redirect is dropped; pop coinciding with redirect is void.
REQ-028 Back-to-back redirects: latest wins; discard counter accumulates correctly.
REQ-029 imem_rsp_valid with zero outstanding is a protocol violation; the response is ignored and a simulation assertion fires.

Reset
REQ-030 On reset: fetch_pc = RESET_PC, buffer pointers, occupancy, outstanding and discard counters = 0.
REQ-031 Outputs during and one cycle after reset: imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, imem_req_addr=RESET_PC.
REQ-032 Reset mid-operation abandons all in-flight requests; instruction memory shares the same reset and returns no stale responses.

Structure
REQ-033 Shared package cpu_pkg holds the fetch entry struct {pc[31:0], inst[31:0]} and the RESET_PC default constant.
REQ-034 Buffer implemented as sub-module fetch_fifo (synchronous FIFO, push/pop/flush, full/empty, count); fetch_unit holds fetch_pc, counters and handshake logic.

Verification
REQ-035 Reset, imem_req_ready=1, 1-cycle memory, inst_ready=1 -> requests at 0,4,8,...; inst_pc 0,4,8 one per cycle from cycle 3.
REQ-036 inst_ready=0, 1-cycle memory -> exactly 4 requests issued, buffer full, imem_req_valid low; raise inst_ready -> fetching resumes at 0x10.
REQ-037 3-cycle memory latency, 2 outstanding, redirect_pc=0x100 -> 2 stale responses dropped; first inst_pc after redirect = 0x100.
REQ-038 redirect_pc=0x203 -> imem_req_addr=0x200 next cycle.
REQ-039 RESET_PC=0xFFFF_FFF8 -> request addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-040 Random imem_req_ready/inst_ready stall, random latency 1-5 -> delivered inst_pc sequence matches reference model; no overflow or lost entries.
